// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring integer divider, one trial subtraction per cycle.
// Define SIGNED_DIV_EN to honour signed_op (two's-complement divide); otherwise unsigned only.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] dividend_r;
    logic             dz_r;

    logic             accept_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH+1:0] trial_s;
    logic             trial_ok_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic             unused_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // Trial subtraction: invert divisor, carry-in 1; MSB set means the difference went negative.
    assign rem_sh_s   = {rem_r, quo_r[WIDTH-1]};
    assign trial_s    = {1'b0, rem_sh_s} + {1'b1, 1'b1, ~div_r} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign trial_ok_s = ~trial_s[WIDTH+1];

`ifdef SIGNED_DIV_EN
    logic q_neg_s;
    logic r_neg_s;
    logic q_neg_r;
    logic r_neg_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    // Operand magnitudes and result signs; MIN / -1 needs no special case since
    // |MIN| / 1 negated wraps back to MIN with a zero remainder.
    always_comb begin
        a_mag_s = dividend;
        b_mag_s = divisor;
        q_neg_s = 1'b0;
        r_neg_s = 1'b0;
        if (signed_op) begin
            a_mag_s = magnitude(dividend);
            b_mag_s = magnitude(divisor);
            q_neg_s = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_s = dividend[WIDTH-1];
        end else begin
            a_mag_s = dividend;
            b_mag_s = divisor;
        end
    end

    // Sign correction applied to the unsigned result in FIX.
    always_comb begin
        quo_fix_s = quo_r;
        rem_fix_s = rem_r;
        if (q_neg_r) begin
            quo_fix_s = negate(quo_r);
        end else begin
            quo_fix_s = quo_r;
        end
        if (r_neg_r) begin
            rem_fix_s = negate(rem_r);
        end else begin
            rem_fix_s = rem_r;
        end
    end

    // Result sign flags captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (accept_s) begin
            q_neg_r <= q_neg_s;
            r_neg_r <= r_neg_s;
        end else begin
            q_neg_r <= q_neg_r;
            r_neg_r <= r_neg_r;
        end
    end

    assign unused_s = trial_s[WIDTH];
`else
    assign a_mag_s   = dividend;
    assign b_mag_s   = divisor;
    assign quo_fix_s = quo_r;
    assign rem_fix_s = rem_r;
    assign unused_s  = trial_s[WIDTH] ^ signed_op;
`endif

    // Control FSM, shift/subtract datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            div_r       <= {WIDTH{1'b0}};
            dividend_r  <= {WIDTH{1'b0}};
            dz_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dividend_r <= dividend;
                        quo_r      <= a_mag_s;
                        div_r      <= b_mag_s;
                        rem_r      <= {WIDTH{1'b0}};
                        dz_r       <= (divisor == {WIDTH{1'b0}});
                        cnt_r      <= CNT_LOAD;
                        busy       <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rem_r <= trial_ok_s ? trial_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], trial_ok_s};
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient    <= dz_r ? {WIDTH{1'b1}} : quo_fix_s;
                    remainder   <= dz_r ? dividend_r : rem_fix_s;
                    div_by_zero <= dz_r;
                    done        <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: stimulus pushes expected results, a monitor pops on done.
module tb_alu_divider;

    localparam int WIDTH     = 32;
    localparam int LAT_EDGES = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        done_d = 1'b0;
    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    alu_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; signed truncates toward zero, remainder follows dividend.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic use_s;
        int   sa;
        int   sb;
`ifdef SIGNED_DIV_EN
        use_s = s;
`else
        use_s = s & 1'b0;
`endif
        sa = a;
        sb = b;
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (use_s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            chk("done_one_cycle", {31'd0, done_d}, 32'd0);
            chk("busy_in_done", {31'd0, busy}, 32'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                chk("latency_edges", 32'(cyc - e.acc), 32'(LAT_EDGES));
                last_q = e.q;
                last_r = e.r;
            end
        end
        done_d <= done;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        exp_t        e;
        int          k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (push) begin
            model(a, b, s, q, r, dz);
            e.q   = q;
            e.r   = r;
            e.dz  = dz;
            e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 80) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] dir_a [12] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678,
                                32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'd0,
                                32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] dir_b [12] = '{32'd7, 32'd2, 32'd2, 32'd0,
                                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                32'd9, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF9};
    logic        dir_s [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        rst_n = 1'b0;
        start = 1'b0;
        signed_op = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++) issue(dir_a[i], dir_b[i], dir_s[i], 1'b1);

        // Starts while busy are ignored; re-accept right after done.
        issue(32'd1000, 32'd3, 1'b0, 1'b1);
        dividend = 32'd55;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("hold_quotient", quotient, last_q);
        chk("hold_remainder", remainder, last_r);
        dividend = 32'd77;
        divisor  = 32'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        wait_done();
        issue(32'd999, 32'd10, 1'b0, 1'b1);

        // Reset mid-operation aborts with no done.
        issue(32'hDEAD_BEEF, 32'd13, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(posedge clk);
        issue(32'hDEAD_BEEF, 32'd13, 1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = 32'd0 - 32'($urandom_range(1, 9));
                4: b = a >> $urandom_range(0, 8);
                default: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
            endcase
            issue(a, b, 1'($urandom_range(0, 1)), 1'b1);
        end

        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_divider.md
# alu_divider

Multi-cycle restoring integer divider that sits beside the ripple ALU in the execute stage and performs the inverse of its arithmetic path: one trial subtraction (invert-b, carry-in 1) per cycle, sign of the difference deciding each quotient bit. It accepts an operand pair on a start pulse, stays busy for a fixed number of cycles, then presents quotient and remainder with a one-cycle done strobe. Results hold until the next accepted start.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- signed_op  input  1  1 = two's-complement divide (sampled with start)
- dividend  input  WIDTH  sampled on accepted start
- divisor  input  WIDTH  sampled on accepted start
- busy  output  1  high from cycle after accept until done cycle inclusive
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag, valid with done, held with results

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 → latch operands, compute magnitudes (if signed), record result signs (q_neg = sign(a) xor sign(b), r_neg = sign(a)), clear partial remainder, load counter = WIDTH-1 → RUN. start=0 → stay.
- RUN: each cycle shift {rem, quo} left by 1; trial = rem − |divisor| (WIDTH+1 bits); trial non-negative → rem = trial, quotient bit 1; else quotient bit 0. Counter decrements; at 0 → FIX.
- FIX: apply sign correction (negate quotient if q_neg, remainder if r_neg); apply divide-by-zero override; load output registers → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Divide by zero (divisor==0): quotient = all ones, remainder = original dividend (unmodified, both modes), div_by_zero=1. Same latency as normal.
- Signed overflow (dividend = most-negative, divisor = −1): quotient = most-negative, remainder = 0, div_by_zero=0.
- Remainder sign follows dividend; quotient truncates toward zero.
- start while busy=1 (RUN/FIX/DONE) ignored; no queueing.
- Outputs quotient/remainder/div_by_zero change only in FIX; otherwise hold.

## Timing
- Reset (async assert, sync deassert handled upstream): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal regs 0.
- Reset mid-operation aborts immediately; no done issued; outputs return to 0.
- Accept at edge N (start=1, IDLE) → busy=1 from N+1; RUN occupies N+1..N+WIDTH; FIX at N+WIDTH+1; done=1 and results valid during cycle N+WIDTH+2; busy falls to 0 in N+WIDTH+3.
- Total latency start-to-done: WIDTH+2 cycles (34 at WIDTH=32), independent of operands.
- Back-to-back: start may be asserted in the cycle after done; earliest re-accept at N+WIDTH+3.

## Configuration
- SIGNED_DIV_EN defined: signed_op honoured as above (magnitude conversion in IDLE, sign fix in FIX, overflow rule applies).
- SIGNED_DIV_EN undefined: signed_op ignored, all operations unsigned; magnitude and sign-fix logic not built; FIX still occupies one cycle so latency is unchanged.

## Test plan
- Unsigned, WIDTH=32: dividend=100, divisor=7, signed_op=0 → done exactly 34 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
- Signed (SIGNED_DIV_EN): dividend=−7 (0xFFFFFFF9), divisor=2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1); without macro same stimulus → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: dividend=0x12345678, divisor=0, either mode → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, latency 34.
- Overflow (SIGNED_DIV_EN): dividend=0x80000000, divisor=0xFFFFFFFF, signed_op=1 → quotient=0x80000000, remainder=0, div_by_zero=0.
- Busy protocol: pulse start again at cycles N+1 and N+20 with different operands → ignored, single done at N+34 with first results; start at N+35 accepted, done at N+69.
- Reset mid-op: assert rst_n=0 at N+10 → busy, done, outputs 0 immediately; no done pulse; fresh start after release yields correct result with full latency.
